// File: rtl/dbg_run_ctrl.sv
// Run-control sequencer for the debug-clocked core: halt/run/step/reset commands,
// core clock enable, core reset request and a single PC breakpoint.
module dbg_run_ctrl #(
    parameter int CNT_W        = 16,
    parameter int RESET_CYCLES = 4,
    parameter int RUN_ON_RESET = 0
) (
    input  logic             sysclk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_arg,
    input  logic             bp_en,
    input  logic [31:0]      bp_addr,
    input  logic [31:0]      pc,
    output logic             clk_en,
    output logic             dm_reset,
    output logic             halted,
    output logic             bp_hit,
    output logic             cmd_err,
    output logic [31:0]      cycle_count
);

    typedef enum logic [1:0] {
        ST_HALTED    = 2'd0,
        ST_RUNNING   = 2'd1,
        ST_STEPPING  = 2'd2,
        ST_RESETTING = 2'd3
    } state_t;

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_HALT  = 3'd1;
    localparam logic [2:0] OP_RUN   = 3'd2;
    localparam logic [2:0] OP_STEP  = 3'd3;
    localparam logic [2:0] OP_RESET = 3'd4;

    localparam int     RST_W     = (RESET_CYCLES < 2) ? 1 : $clog2(RESET_CYCLES + 1);
    localparam state_t ST_INIT   = (RUN_ON_RESET != 0) ? ST_RUNNING : ST_HALTED;
    localparam logic   RUN_INIT  = (RUN_ON_RESET != 0);

    state_t             state_q, state_d;
    logic               run_q, run_d;
    logic               dm_reset_q, dm_reset_d;
    logic               bp_hit_q, bp_hit_d;
    logic               cmd_err_q, cmd_err_d;
    logic               bp_skip_q, bp_skip_d;
    logic [CNT_W-1:0]   step_cnt_q, step_cnt_d;
    logic [RST_W-1:0]   rst_cnt_q, rst_cnt_d;
    logic [31:0]        cycle_count_q, cycle_count_d;

    logic bp_stop;
    logic accept;

    // Breakpoint gates the core edge in the very cycle the PC matches.
    assign bp_stop     = bp_en & (pc == bp_addr) & ~bp_skip_q;
    assign clk_en      = run_q & ~bp_stop;
    assign cmd_ready   = (state_q != ST_RESETTING);
    assign accept      = cmd_valid & cmd_ready;
    assign dm_reset    = dm_reset_q;
    assign halted      = (state_q == ST_HALTED);
    assign bp_hit      = bp_hit_q;
    assign cmd_err     = cmd_err_q;
    assign cycle_count = cycle_count_q;

    always_comb begin
        state_d       = state_q;
        bp_hit_d      = bp_hit_q;
        cmd_err_d     = cmd_err_q;
        bp_skip_d     = bp_skip_q;
        step_cnt_d    = step_cnt_q;
        rst_cnt_d     = rst_cnt_q;
        cycle_count_d = cycle_count_q;

        if (clk_en)
            cycle_count_d = cycle_count_q + 32'd1;
        if (run_q)
            bp_skip_d = 1'b0;

        // Internal progress; an accepted command below overrides it.
        if (run_q && bp_stop) begin
            state_d  = ST_HALTED;
            bp_hit_d = 1'b1;
        end else if (state_q == ST_STEPPING && clk_en) begin
            step_cnt_d = step_cnt_q - CNT_W'(1);
            if (step_cnt_q <= CNT_W'(1))
                state_d = ST_HALTED;
        end
        if (state_q == ST_RESETTING) begin
            rst_cnt_d = rst_cnt_q - RST_W'(1);
            if (rst_cnt_q <= RST_W'(1))
                state_d = ST_HALTED;
        end

        if (accept) begin
            case (cmd_op)
                OP_NOP: ;
                OP_HALT: state_d = ST_HALTED;
                OP_RUN: begin
                    state_d   = ST_RUNNING;
                    bp_hit_d  = 1'b0;
                    cmd_err_d = 1'b0;
                    bp_skip_d = 1'b1;
                end
                OP_STEP: begin
                    state_d    = ST_STEPPING;
                    step_cnt_d = (cmd_arg == '0) ? CNT_W'(1) : cmd_arg;
                    bp_hit_d   = 1'b0;
                    cmd_err_d  = 1'b0;
                    bp_skip_d  = 1'b1;
                end
                OP_RESET: begin
                    state_d       = ST_RESETTING;
                    rst_cnt_d     = RST_W'(RESET_CYCLES);
                    bp_hit_d      = 1'b0;
                    cmd_err_d     = 1'b0;
                    cycle_count_d = '0;
                end
                default: cmd_err_d = 1'b1;
            endcase
        end

        run_d      = (state_d == ST_RUNNING) || (state_d == ST_STEPPING);
        dm_reset_d = (state_d == ST_RESETTING);
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_INIT;
            run_q         <= RUN_INIT;
            dm_reset_q    <= 1'b0;
            bp_hit_q      <= 1'b0;
            cmd_err_q     <= 1'b0;
            bp_skip_q     <= 1'b0;
            step_cnt_q    <= '0;
            rst_cnt_q     <= '0;
            cycle_count_q <= '0;
        end else begin
            state_q       <= state_d;
            run_q         <= run_d;
            dm_reset_q    <= dm_reset_d;
            bp_hit_q      <= bp_hit_d;
            cmd_err_q     <= cmd_err_d;
            bp_skip_q     <= bp_skip_d;
            step_cnt_q    <= step_cnt_d;
            rst_cnt_q     <= rst_cnt_d;
            cycle_count_q <= cycle_count_d;
        end
    end

endmodule

// File: doc/dbg_run_ctrl.md
# dbg_run_ctrl

Run-control sequencer for the debug-clocked RISC-V core. Sits between the JTAG debug register file and the clock-gating cell that produces `dbgclk` from `sysclk`. It accepts halt, run, step and reset commands and drives the core clock enable and `dm_reset`. It also implements a single PC breakpoint that stops the core with `PCF` holding the breakpoint address.

## Interface
Parameters:
- `CNT_W`, 16: width of step-count argument.
- `RESET_CYCLES`, 4: sysclk cycles `dm_reset` is held high per RESET command (>=1).
- `RUN_ON_RESET`, 0: 1 = enter RUNNING out of async reset; 0 = HALTED.

Ports:
- `sysclk`  in  1  clock; all logic on rising edge.
- `reset`  in  1  reset, asynchronous, active-high.
- `cmd_valid`  in  1  command request (already synchronized to sysclk).
- `cmd_ready`  out  1  command can be accepted this cycle.
- `cmd_op`  in  3  0 NOP, 1 HALT, 2 RUN, 3 STEP, 4 RESET, 5-7 illegal.
- `cmd_arg`  in  CNT_W  step count for STEP.
- `bp_en`  in  1  breakpoint enable (level).
- `bp_addr`  in  32  breakpoint PC.
- `pc`  in  32  core fetch PC (`PCF` after boundary scan).
- `clk_en`  out  1  enable to glitch-free clock gate; core sees an edge at end of every sysclk cycle with `clk_en`=1.
- `dm_reset`  out  1  core reset request, registered.
- `halted`  out  1  state == HALTED.
- `bp_hit`  out  1  sticky: last stop was caused by breakpoint.
- `cmd_err`  out  1  sticky: illegal opcode accepted.
- `cycle_count`  out  32  count of enabled core cycles.

## Operation
- States: HALTED, RUNNING, STEPPING, RESETTING.
- Handshake: accept on `cmd_valid && cmd_ready`. `cmd_ready` = 0 in RESETTING, else 1.
- Accepted commands, any non-RESETTING state:
  - HALT -> HALTED.
  - RUN -> RUNNING.
  - STEP -> STEPPING with `step_cnt` = `cmd_arg`; `cmd_arg`=0 treated as 1. STEP while STEPPING reloads the count.
  - RESET -> RESETTING with `rst_cnt` = RESET_CYCLES.
  - NOP: no effect.
  - Illegal opcode: no state change, `cmd_err` set.
- RUN, STEP and RESET clear `bp_hit` and `cmd_err`. RESET also clears `cycle_count`.
- `clk_en` = `run_q & ~bp_stop`:
  - `run_q` is registered, 1 in RUNNING/STEPPING.
  - `bp_stop` = `bp_en & (pc == bp_addr) & ~bp_skip`. This combinational term gates the edge in the same cycle, so the core halts with `pc` == `bp_addr`, instruction not fetched past.
- `bp_skip` is set on accept of RUN/STEP and cleared after the first cycle with `run_q`=1. Resuming from a breakpoint therefore executes past it.
- When `bp_stop`=1 with `run_q`=1: next state HALTED, `bp_hit` set. A breakpoint during STEPPING aborts the remaining steps.
- STEPPING: `step_cnt` decrements each cycle with `clk_en`=1. At the decrement that reaches 0, next state is HALTED.
- RESETTING: `dm_reset`=1, `clk_en`=0. `rst_cnt` decrements each cycle; at 0, `dm_reset` drops and state goes to HALTED.
- `cycle_count` increments on each cycle with `clk_en`=1 and wraps 2^32-1 -> 0.

## Timing
- Async reset values:
  - state HALTED, or RUNNING if RUN_ON_RESET.
  - `run_q` = RUN_ON_RESET.
  - `dm_reset` 0, `bp_hit` 0, `cmd_err` 0, `cycle_count` 0.
  - `step_cnt` 0, `rst_cnt` 0, `bp_skip` 0.
  - `cmd_ready` 1, `halted` = !RUN_ON_RESET.
- Command accepted at edge t: new `run_q`/`dm_reset` values are visible from cycle t+1.
- STEP N accepted at edge t: `clk_en`=1 for cycles t+1..t+N exactly (no breakpoint), `halted`=1 from cycle t+N+1.
- HALT accepted at edge t: last enabled cycle is t; `clk_en`=0 from t+1.
- RESET accepted at edge t: `dm_reset`=1 for cycles t+1..t+RESET_CYCLES, `cmd_ready`=0 over the same cycles, HALTED at t+RESET_CYCLES+1.
- Breakpoint match in cycle c: `clk_en`=0 in c (combinational), `halted`=1 and `bp_hit`=1 from c+1.
- Async reset mid-STEP or mid-RESET: abort immediately to reset values; no pending count survives.
- `pc`/`bp_addr` changes while HALTED have no effect (`run_q`=0).

## Test plan
- Async reset, RUN_ON_RESET=0 -> `halted`=1, `clk_en`=0, `cycle_count`=0, `cmd_ready`=1.
- STEP `cmd_arg`=5 -> `clk_en` high exactly 5 cycles, `cycle_count`=5, `halted`=1; STEP `cmd_arg`=0 -> exactly 1 enabled cycle.
- RUN with `bp_en`=1, `bp_addr`=0x0000_0010, `pc` advancing by 4 -> `clk_en` drops in the cycle `pc`=0x10, `bp_hit`=1; a following RUN gives `clk_en`=1 on the first cycle despite the match, then keeps running.
- RESET with RESET_CYCLES=4 -> `dm_reset` high 4 cycles, `cmd_ready`=0 throughout, a HALT presented then is not accepted; ends HALTED with `cycle_count`=0.
- STEP `cmd_arg`=100, HALT at step 10 -> `clk_en` stops after cycle 10; `cmd_op`=6 -> `cmd_err`=1, state unchanged; next RUN clears `cmd_err`.
- `cycle_count` preloaded near wrap (force) at 0xFFFF_FFFE, RUN 3 cycles -> value 0x0000_0001.
